// File: rtl/phase_interpolator.sv
// Sparse-sample linear interpolator: one fetched sample per phase segment,
// signed 8-bit output every clock with a two-stage multiply pipeline.
module phase_interpolator #(
   parameter int SEG_BIT   = 29,
   parameter int FRAC_BITS = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] phase,
   output logic        sample_req,
   input  logic [7:0]  sample_in,
   input  logic        sample_valid,
   output logic [7:0]  interp,
   output logic        interp_valid,
   output logic        overrun
);

   localparam int PW = 10 + FRAC_BITS;

   typedef enum logic [1:0] {
      PRIME0,
      PRIME1,
      RUN,
      WAIT
   } state_t;

   state_t r_state;

   logic [7:0] r_a;
   logic [7:0] r_b;
   logic       r_pending;
   logic       r_prev_seg;
   logic       r_b_stale;
   logic       r_req;
   logic       r_overrun;

   logic signed [7:0]           r_s1_a;
   logic signed [8:0]           r_s1_diff;
   logic [FRAC_BITS-1:0]        r_s1_frac;
   logic                        r_s1_vld;
   logic [7:0]                  r_interp;
   logic                        r_ivld;

   logic                        w_seg_edge;
   logic                        w_take;
   logic [7:0]                  w_b_eff;
   logic [8:0]                  w_diff;
   logic [FRAC_BITS-1:0]        w_frac;
   logic signed [FRAC_BITS:0]   w_frac_s;
   logic signed [PW-1:0]        w_prod;
   logic signed [PW-1:0]        w_shift;
   logic                        w_unused;

   assign w_seg_edge = phase[SEG_BIT] ^ r_prev_seg;
   assign w_take     = sample_valid & r_pending;
   assign w_frac     = phase[SEG_BIT-1 -: FRAC_BITS];
   assign w_unused   = ^phase;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= PRIME0;
         r_a        <= 8'h00;
         r_b        <= 8'h00;
         r_pending  <= 1'b0;
         r_prev_seg <= 1'b0;
         r_b_stale  <= 1'b0;
         r_req      <= 1'b0;
         r_overrun  <= 1'b0;
      end else begin
         r_req      <= 1'b0;
         r_prev_seg <= phase[SEG_BIT];
         unique case (r_state)
            PRIME0: begin
               if (!r_pending) begin
                  r_req     <= 1'b1;
                  r_pending <= 1'b1;
               end else if (sample_valid) begin
                  r_b     <= sample_in;
                  r_req   <= 1'b1;
                  r_state <= PRIME1;
               end
            end
            PRIME1: begin
               if (w_take) begin
                  r_a       <= r_b;
                  r_b       <= sample_in;
                  r_pending <= 1'b0;
                  r_state   <= RUN;
               end
            end
            RUN: begin
               if (w_seg_edge) begin
                  r_a       <= r_b;
                  r_b_stale <= 1'b1;
                  r_req     <= 1'b1;
                  r_pending <= 1'b1;
                  r_state   <= WAIT;
               end
            end
            WAIT: begin
               // Sample lands first, then the boundary consumes it at once.
               if (w_take && w_seg_edge) begin
                  r_a   <= sample_in;
                  r_b   <= sample_in;
                  r_req <= 1'b1;
               end else if (w_take) begin
                  r_b       <= sample_in;
                  r_b_stale <= 1'b0;
                  r_pending <= 1'b0;
                  r_state   <= RUN;
               end else if (w_seg_edge) begin
                  r_overrun <= 1'b1;
                  r_a       <= r_b;
               end
            end
            default: r_state <= PRIME0;
         endcase
      end
   end

   assign w_b_eff  = r_b_stale ? r_a : r_b;
   assign w_diff   = {w_b_eff[7], w_b_eff} - {r_a[7], r_a};
   assign w_frac_s = {1'b0, r_s1_frac};
   assign w_prod   = PW'(r_s1_diff) * PW'(w_frac_s);
   assign w_shift  = w_prod >>> FRAC_BITS;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_a    <= '0;
         r_s1_diff <= '0;
         r_s1_frac <= '0;
         r_s1_vld  <= 1'b0;
         r_interp  <= 8'h00;
         r_ivld    <= 1'b0;
      end else begin
         r_s1_a    <= r_a;
         r_s1_diff <= w_diff;
         r_s1_frac <= w_frac;
         r_s1_vld  <= (r_state == RUN) || (r_state == WAIT);
         r_interp  <= 8'(PW'(r_s1_a) + w_shift);
         r_ivld    <= r_s1_vld;
      end
   end

   assign sample_req   = r_req;
   assign interp       = r_interp;
   assign interp_valid = r_ivld;
   assign overrun      = r_overrun;

endmodule
